// File: rtl/vga_pkg.sv
// Shared VGA timing constants, counter width and the output-stage state type.
package vga_pkg;

    // 640x480 @ 60 Hz horizontal timing, in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Raster counter width; wide enough for any total up to 4095
    localparam int CNT_W = 12;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } vo_state_e;

    // True when pos lies in the half-open window [lo, lo+len)
    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding upstream pixels.
// Push on a full FIFO and pop on an empty FIFO are ignored.
module vga_sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Next pointers and occupancy; simultaneous push and pop leave count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vga_stage_output.sv
// Final pipeline stage: buffers positioned pixels, generates VGA raster timing,
// and locks the pixel stream to the raster at frame start.
//
// Handshake: a pixel is taken when st__valid_1a is high and vg__stall is low
// at a rising clk edge; vg__stall is a register, so upstream sees it one
// cycle late and the FIFO keeps two entries of headroom for that.
module vga_stage_output
    import vga_pkg::*;
#(
    parameter int WIDTHBITS  = 10,
    parameter int HEIGHTBITS = 10,
    parameter int COLORBITS  = 8,
    parameter int FIFODEPTH  = 16,
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FRONT_P  = H_FRONT,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_BACK_P   = H_BACK,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FRONT_P  = V_FRONT,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BACK_P   = V_BACK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORBITS-1:0]  st__color_1a,
    input  logic [WIDTHBITS-1:0]  st__x_1a,
    input  logic [HEIGHTBITS-1:0] st__y_1a,
    input  logic                  st__valid_1a,
    output logic                  vg__stall,
    output logic [COLORBITS-1:0]  vga_color,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_blank,
    output logic                  vo__locked,
    output logic                  vo__underrun,
    output logic                  vo__resync
);

    localparam int FW    = COLORBITS + WIDTHBITS + HEIGHTBITS;
    localparam int AW    = $clog2(FIFODEPTH);
    localparam int H_TOT = H_ACTIVE_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
    localparam int V_TOT = V_ACTIVE_P + V_FRONT_P + V_SYNC_P + V_BACK_P;
    localparam logic [AW:0] STALL_AT = (AW+1)'(FIFODEPTH - 2);

    logic [CNT_W-1:0]     hcnt_q, hcnt_d;
    logic [CNT_W-1:0]     vcnt_q, vcnt_d;
    vo_state_e            state_q, state_d;
    logic                 stall_q, stall_d;
    logic [COLORBITS-1:0] color_q, color_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 blank_q, blank_d;
    logic                 underrun_q, underrun_d;
    logic                 resync_q, resync_d;

    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [FW-1:0]         fifo_head;
    logic [AW:0]           fifo_count;
    logic [COLORBITS-1:0]  head_color;
    logic [WIDTHBITS-1:0]  head_x;
    logic [HEIGHTBITS-1:0] head_y;
    logic                  active, at_origin, head_origin, head_match;

    assign fifo_push = st__valid_1a && !stall_q;

    vga_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  ({st__color_1a, st__x_1a, st__y_1a}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_color = fifo_head[FW-1 -: COLORBITS];
    assign head_x     = fifo_head[HEIGHTBITS +: WIDTHBITS];
    assign head_y     = fifo_head[HEIGHTBITS-1:0];

    assign active      = (hcnt_q < CNT_W'(H_ACTIVE_P)) && (vcnt_q < CNT_W'(V_ACTIVE_P));
    assign at_origin   = (hcnt_q == '0) && (vcnt_q == '0);
    assign head_origin = !fifo_empty && (head_x == '0) && (head_y == '0);
    assign head_match  = !fifo_empty && (CNT_W'(head_x) == hcnt_q) && (CNT_W'(head_y) == vcnt_q);

    // Free-running raster counters: hcnt wraps at the line end and steps vcnt
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == CNT_W'(H_TOT - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == CNT_W'(V_TOT - 1)) vcnt_d = '0;
            else                             vcnt_d = vcnt_q + 1'b1;
        end
    end

    // Lock FSM: decides pops, the next DAC colour and the sticky error flags.
    // On locking, the origin pixel is shown in the same cycle so that the
    // following head lines up with (1,0).
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        color_d    = '0;
        underrun_d = underrun_q;
        resync_d   = resync_q;
        case (state_q)
            SYNC_WAIT: begin
                if (!fifo_empty) begin
                    if (!head_origin) begin
                        fifo_pop = 1'b1;
                    end else if (at_origin) begin
                        fifo_pop = 1'b1;
                        color_d  = head_color;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (active) begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                        state_d    = SYNC_WAIT;
                    end else if (!head_match) begin
                        fifo_pop = 1'b1;
                        resync_d = 1'b1;
                        state_d  = SYNC_WAIT;
                    end else begin
                        fifo_pop = 1'b1;
                        color_d  = head_color;
                    end
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
    end

    // Sync, blank and back-pressure decode for the output registers
    always_comb begin
        hsync_d = !in_window(hcnt_q, H_ACTIVE_P + H_FRONT_P, H_SYNC_P);
        vsync_d = !in_window(vcnt_q, V_ACTIVE_P + V_FRONT_P, V_SYNC_P);
        blank_d = !active;
        stall_d = (fifo_count >= STALL_AT);
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            state_q    <= SYNC_WAIT;
            stall_q    <= 1'b0;
            color_q    <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b1;
            underrun_q <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            state_q    <= state_d;
            stall_q    <= stall_d;
            color_q    <= color_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            blank_q    <= blank_d;
            underrun_q <= underrun_d;
            resync_q   <= resync_d;
        end
    end

    assign vg__stall    = stall_q;
    assign vga_color    = color_q;
    assign vga_hsync    = hsync_q;
    assign vga_vsync    = vsync_q;
    assign vga_blank    = blank_q;
    assign vo__locked   = (state_q == RUN);
    assign vo__underrun = underrun_q;
    assign vo__resync   = resync_q;

endmodule

// File: tb/tb_vga_stage_output.sv
// Bench for vga_stage_output with a shrunken raster (160x20 totals) so that
// several frames fit in a short run. A reference model derives position from
// elapsed cycles and keeps the pixel FIFO as a queue; a monitor compares.
module tb_vga_stage_output;

  localparam int H_ACT = 128, H_FP = 8, H_SY = 16, H_BP = 8;
  localparam int V_ACT = 12,  V_FP = 2, V_SY = 2,  V_BP = 4;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [7:0] color;
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

  typedef struct packed {
    logic [7:0]  color;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        locked;
    logic        under;
    logic        resync;
    logic        stall;
    logic [4:0]  count;
    logic [15:0] h;
    logic [15:0] v;
  } out_t;

  logic       clk, rst;
  logic [7:0] st__color_1a;
  logic [9:0] st__x_1a, st__y_1a;
  logic       st__valid_1a;
  logic       vg__stall;
  logic [7:0] vga_color;
  logic       vga_hsync, vga_vsync, vga_blank;
  logic       vo__locked, vo__underrun, vo__resync;

  int errors = 0;
  int checks = 0;

  vga_stage_output #(
    .WIDTHBITS(10), .HEIGHTBITS(10), .COLORBITS(8), .FIFODEPTH(DEPTH),
    .H_ACTIVE_P(H_ACT), .H_FRONT_P(H_FP), .H_SYNC_P(H_SY), .H_BACK_P(H_BP),
    .V_ACTIVE_P(V_ACT), .V_FRONT_P(V_FP), .V_SYNC_P(V_SY), .V_BACK_P(V_BP)
  ) u_dut (
    .clk(clk), .rst(rst),
    .st__color_1a(st__color_1a), .st__x_1a(st__x_1a), .st__y_1a(st__y_1a),
    .st__valid_1a(st__valid_1a),
    .vg__stall(vg__stall), .vga_color(vga_color), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_blank(vga_blank), .vo__locked(vo__locked),
    .vo__underrun(vo__underrun), .vo__resync(vo__resync)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  out_t exp_q[$];
  pix_t model_q[$];
  int   m_t = 0;
  bit   m_run = 0, m_stall = 0, m_under = 0, m_resync = 0;

  always @(posedge clk) begin : model_b
    out_t e;
    int h, v, pre;
    bit act, do_pop, acc;
    logic [7:0] col;
    pix_t np;
    if (rst) begin
      model_q.delete();
      m_t = 0; m_run = 0; m_stall = 0; m_under = 0; m_resync = 0;
      e = '{color: 8'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1, locked: 1'b0, under: 1'b0,
            resync: 1'b0, stall: 1'b0, count: 5'd0, h: 16'hFFFF, v: 16'hFFFF};
    end else begin
      h = m_t % H_TOT;
      v = (m_t / H_TOT) % V_TOT;
      act = (h < H_ACT) && (v < V_ACT);
      pre = model_q.size();
      acc = st__valid_1a && !m_stall;
      do_pop = 0;
      col = 8'd0;
      if (!m_run) begin
        if (pre > 0) begin
          if (model_q[0].x != 0 || model_q[0].y != 0) do_pop = 1;
          else if (h == 0 && v == 0) begin do_pop = 1; col = model_q[0].color; m_run = 1; end
        end
      end else if (act) begin
        if (pre == 0) begin
          m_under = 1; m_run = 0;
        end else if (int'(model_q[0].x) != h || int'(model_q[0].y) != v) begin
          do_pop = 1; m_resync = 1; m_run = 0;
        end else begin
          do_pop = 1; col = model_q[0].color;
        end
      end
      m_stall = (pre >= DEPTH - 2);
      if (do_pop) void'(model_q.pop_front());
      if (acc) begin
        np.color = st__color_1a; np.x = st__x_1a; np.y = st__y_1a;
        model_q.push_back(np);
      end
      e.color  = col;
      e.hs     = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SY);
      e.vs     = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SY);
      e.blank  = !act;
      e.locked = m_run;
      e.under  = m_under;
      e.resync = m_resync;
      e.stall  = m_stall;
      e.count  = 5'(model_q.size());
      e.h      = 16'(h);
      e.v      = 16'(v);
      m_t++;
    end
    exp_q.push_back(e);
  end

  // ---------------- scoreboard monitor ----------------
  int   max_cnt = 0;
  bit   stall_seen = 0;

  always @(negedge clk) begin : monitor_b
    out_t e;
    logic [4:0] cnt;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cnt = 5'(u_dut.u_fifo.count_o);
      checks++;
      if (vga_color !== e.color || vga_hsync !== e.hs || vga_vsync !== e.vs ||
          vga_blank !== e.blank || vo__locked !== e.locked || vo__underrun !== e.under ||
          vo__resync !== e.resync || vg__stall !== e.stall || cnt !== e.count) begin
        errors++;
        $display("FAIL out_cycle pos=(%0d,%0d) got col=%h hs=%b vs=%b bl=%b lk=%b ur=%b rs=%b st=%b cnt=%0d want col=%h hs=%b vs=%b bl=%b lk=%b ur=%b rs=%b st=%b cnt=%0d",
                 e.h, e.v, vga_color, vga_hsync, vga_vsync, vga_blank, vo__locked, vo__underrun,
                 vo__resync, vg__stall, cnt, e.color, e.hs, e.vs, e.blank, e.locked, e.under,
                 e.resync, e.stall, e.count);
      end
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      if (vg__stall) stall_seen = 1;
      if (e.h == 16'd5 && e.v == 16'd0 && e.locked) begin
        checks++;
        if (vga_color !== 8'h5A) begin
          errors++;
          $display("FAIL pixel_5_0 got=%h want=5a", vga_color);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int   sx, sy;
  logic [7:0] cur_c;
  int   cur_x, cur_y;
  bit   stream_on = 0, gap_mode = 0, inject = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic load_cur();
    cur_c = (sx == 5 && sy == 0) ? 8'h5A : 8'($urandom_range(0, 255));
    cur_y = sy;
    cur_x = sx;
    if (inject && sx == 99 && sy == 10) begin
      cur_x = 100;
      inject = 0;
    end
  endtask

  task automatic stream_start(input int x, input int y);
    sx = x; sy = y;
    load_cur();
  endtask

  task automatic advance();
    sx++;
    if (sx == H_ACT) begin
      sx = 0; sy++;
      if (sy == V_ACT) sy = 0;
    end
    load_cur();
  endtask

  // One clock: note acceptance before the edge, update inputs #1 after it
  task automatic cycle();
    bit acc;
    @(negedge clk);
    acc = st__valid_1a && !vg__stall && !rst;
    @(posedge clk);
    #1;
    if (acc) advance();
    st__valid_1a = stream_on && (!gap_mode || $urandom_range(0, 3) != 0);
    st__color_1a = cur_c;
    st__x_1a     = 10'(cur_x);
    st__y_1a     = 10'(cur_y);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_lock(input int budget, input string tag);
    int n = 0;
    while (!vo__locked && n < budget) begin cycle(); n++; end
    chk(tag, int'(vo__locked), 1);
  endtask

  // Return when the next edge will process raster position (h,v)
  task automatic wait_pos(input int h, input int v, input int budget, input string tag);
    int n = 0;
    while (!((m_t % H_TOT) == h && ((m_t / H_TOT) % V_TOT) == v) && n < budget) begin
      cycle(); n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    st__valid_1a = 1'b0; st__color_1a = '0; st__x_1a = '0; st__y_1a = '0;
    stream_start(0, 0);
    cycle(); cycle();
    rst = 1'b0;

    // Reset state
    chk("rst_locked", int'(vo__locked), 0);
    chk("rst_stall",  int'(vg__stall), 0);
    chk("rst_blank",  int'(vga_blank), 1);
    chk("rst_hsync",  int'(vga_hsync), 1);
    chk("rst_color",  int'(vga_color), 0);

    // Continuous stream from the origin: lock at the next frame start
    stream_on = 1;
    stream_start(0, 0);
    wait_lock(2 * FRAME, "lock_origin_stream");
    chk("lock_at_frame_start", (m_t - 1) % FRAME, 0);
    repeat (FRAME) cycle();
    chk("clean_underrun", int'(vo__underrun), 0);
    chk("clean_resync",   int'(vo__resync), 0);
    chk("clean_locked",   int'(vo__locked), 1);

    // Stream starting mid-frame: discard until origin, then lock
    do_reset();
    stream_start(3, 7);
    wait_lock(3 * FRAME, "lock_after_discard");
    chk("discard_lock_frame_start", (m_t - 1) % FRAME, 0);

    // Valid dropped for 40 cycles mid-line while locked
    wait_pos(50, 2, FRAME, "reach_underrun_pos");
    stream_on = 0;
    repeat (40) cycle();
    chk("underrun_flag",   int'(vo__underrun), 1);
    chk("underrun_unlock", int'(vo__locked), 0);
    chk("underrun_color",  int'(vga_color), 0);
    stream_on = 1;
    wait_lock(3 * FRAME, "relock_after_underrun");
    chk("underrun_sticky", int'(vo__underrun), 1);

    // Pixel (100,10) injected where (99,10) belongs
    inject = 1;
    wait_pos(101, 10, 2 * FRAME, "reach_resync_pos");
    chk("resync_flag",   int'(vo__resync), 1);
    chk("resync_unlock", int'(vo__locked), 0);

    // Random valid gaps: back-pressure and FIFO bound
    do_reset();
    stream_start(0, 0);
    gap_mode = 1;
    repeat (2 * FRAME) cycle();
    gap_mode = 0;
    chk("stall_seen", int'(stall_seen), 1);
    chk("fifo_max_15", max_cnt, DEPTH - 1);

    // Reset pulsed mid-frame at (100,8)
    do_reset();
    stream_start(0, 0);
    wait_lock(2 * FRAME, "lock_before_midreset");
    wait_pos(100, 8, FRAME, "reach_midreset_pos");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_locked", int'(vo__locked), 0);
    chk("mid_rst_color",  int'(vga_color), 0);
    chk("mid_rst_hsync",  int'(vga_hsync), 1);
    chk("mid_rst_vsync",  int'(vga_vsync), 1);
    chk("mid_rst_blank",  int'(vga_blank), 1);
    chk("mid_rst_flags",  int'({vo__underrun, vo__resync, vg__stall}), 0);
    k = 0;
    while (vga_hsync && k < 2 * H_TOT) begin cycle(); k++; end
    chk("hsync_first_low", k, H_ACT + H_FP + 1);

    repeat (4) cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
